// File: rtl/shift_unit_if.sv
// Request/response bundle for shift_unit: operand/op/amount in, result/carry/error out.
interface shift_unit_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned AW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [2:0]       in_op;
   logic [AW-1:0]    in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_err;
   logic             busy;

   modport master (
      output in_valid, in_data, in_op, in_amt, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_err, busy
   );

   modport slave (
      input  in_valid, in_data, in_op, in_amt, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_err, busy
   );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shifter: up to STEP positions per cycle, carry-out is the last bit shifted out.
// Rotates (ROL/ROR) exist only when SHIFT_UNIT_ROTATE_EN is defined; otherwise they are invalid ops.
module shift_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned STEP  = 1,
   parameter int unsigned AW    = $clog2(WIDTH)
) (
   input logic         clk,
   input logic         reset,
   shift_unit_if.slave bus
);
   localparam int unsigned KW = AW + 1;

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_LSL  = 3'b001;
   localparam logic [2:0] OP_LSR  = 3'b010;
   localparam logic [2:0] OP_ASR  = 3'b011;
`ifdef SHIFT_UNIT_ROTATE_EN
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_q;
   logic [2:0]       op_q;
   logic [AW-1:0]    rem_q;
   logic             carry_q;
   logic             err_q;

   logic             op_ok_c;
   logic             zero_work_c;
   logic             accept_c;
   logic [KW-1:0]    k_wide_c;
   logic [AW-1:0]    k_c;
   logic [AW-1:0]    hi_idx_c;
   logic [AW-1:0]    lo_idx_c;
   logic [KW-1:0]    back_c;
   logic             last_c;
   logic [WIDTH-1:0] shifted_c;
   logic             shift_carry_c;

`ifdef SHIFT_UNIT_ROTATE_EN
   assign op_ok_c = (bus.in_op <= OP_ROR);
`else
   assign op_ok_c = (bus.in_op <= OP_ASR);
`endif

   assign zero_work_c = (bus.in_amt == '0) || (bus.in_op == OP_PASS) || !op_ok_c;
   assign accept_c    = bus.in_valid && (state == IDLE);

   // Step size this cycle; k never exceeds rem, so it always fits in AW bits
   always_comb begin
      k_wide_c = ({1'b0, rem_q} < KW'(STEP)) ? {1'b0, rem_q} : KW'(STEP);
      k_c      = AW'(k_wide_c);
      back_c   = KW'(WIDTH) - {1'b0, k_c};
      hi_idx_c = AW'(back_c);
      lo_idx_c = k_c - AW'(1);
      last_c   = (rem_q == k_c);
   end

   // One partial shift by k; the carry is the last bit leaving the word in that direction
   always_comb begin
      shifted_c     = data_q;
      shift_carry_c = 1'b0;
      case (op_q)
         OP_LSL: begin
            shifted_c     = data_q << k_c;
            shift_carry_c = data_q[hi_idx_c];
         end
         OP_LSR: begin
            shifted_c     = data_q >> k_c;
            shift_carry_c = data_q[lo_idx_c];
         end
         OP_ASR: begin
            shifted_c     = WIDTH'($signed(data_q) >>> k_c);
            shift_carry_c = data_q[lo_idx_c];
         end
`ifdef SHIFT_UNIT_ROTATE_EN
         OP_ROL: begin
            shifted_c     = (data_q << k_c) | (data_q >> back_c);
            shift_carry_c = data_q[hi_idx_c];
         end
         OP_ROR: begin
            shifted_c     = (data_q >> k_c) | (data_q << back_c);
            shift_carry_c = data_q[lo_idx_c];
         end
`endif
         default: ;
      endcase
   end

   // Working registers: captured at accept, updated once per SHIFT cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         op_q    <= OP_PASS;
         rem_q   <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept_c) begin
         data_q  <= bus.in_data;
         op_q    <= bus.in_op;
         rem_q   <= bus.in_amt;
         carry_q <= 1'b0;
         err_q   <= !op_ok_c;
      end else if (state == SHIFT) begin
         data_q  <= shifted_c;
         rem_q   <= rem_q - k_c;
         carry_q <= shift_carry_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nxt = zero_work_c ? DONE : SHIFT;
         SHIFT:   if (last_c) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
         end
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.out_data  = data_q;
   assign bus.out_carry = carry_q;
   assign bus.out_err   = err_q;
endmodule
